pic_ram_writer: RTL and testbench

PIC_RAM_WRITER -- requirements
Module: pic_ram_writer

---
 rtl/pic_pkg.sv | 18 +
 rtl/pic_ram_writer_if.sv | 23 ++
 rtl/pic_ram_writer.sv | 108 ++++++++++
 tb/tb_pic_ram_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared picture geometry and writer FSM states; used by the RAM writer and
// the display-side reader of the picture RAM.
package pic_pkg;

  localparam int PIC_WIDTH  = 48;
  localparam int PIC_HEIGHT = 48;
  localparam int PIC_ADDR_W = 14;
  localparam int PIX_NUM    = PIC_WIDTH * PIC_HEIGHT;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    DONE
  } pic_state_t;

endpackage

// File: rtl/pic_ram_writer_if.sv
// Byte-stream input handshake plus picture-RAM write port of the writer.
// master = the writer itself, slave = stream source / RAM side.
interface pic_ram_writer_if;
  import pic_pkg::*;

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  wr_en;
  logic [PIC_ADDR_W-1:0] wr_addr;
  logic [15:0]           wr_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/pic_ram_writer.sv
// Assembles an RGB565 byte stream (high byte first) into pixels and writes one
// frame into the picture RAM. Optional checksum: PIC_RAM_WRITER_CHECKSUM_EN.
module pic_ram_writer
  import pic_pkg::*;
#(
  parameter int WIDTH  = PIC_WIDTH,
  parameter int HEIGHT = PIC_HEIGHT
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       checksum,
  pic_ram_writer_if.master  bus
);

  localparam int PIX_TOTAL = WIDTH * HEIGHT;
  localparam logic [PIC_ADDR_W-1:0] LAST_ADDR = PIC_ADDR_W'(PIX_TOTAL - 1);

  generate
    if (PIX_TOTAL > 16384 || PIX_TOTAL < 1) begin : g_size_check
      $error("pic_ram_writer: WIDTH*HEIGHT must be in 1..16384");
    end
  endgenerate

  pic_state_t            state;
  pic_state_t            next_state;
  logic                  rx_ready_q;
  logic [7:0]            hi_byte;
  logic [PIC_ADDR_W-1:0] addr_q;
  logic [15:0]           data_q;
  logic                  xfer;
  logic                  in_frame;

  assign xfer     = bus.rx_valid & rx_ready_q;
  assign in_frame = (state == HI) || (state == LO) || (state == WR);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && !abort) next_state = HI;
      HI: begin
        if (abort)     next_state = IDLE;
        else if (xfer) next_state = LO;
      end
      LO: begin
        if (abort)     next_state = IDLE;
        else if (xfer) next_state = WR;
      end
      WR: begin
        if (abort)                  next_state = IDLE;
        else if (addr_q == LAST_ADDR) next_state = DONE;
        else                        next_state = HI;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rx_ready is registered from the next state so it never depends on rx_valid
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_ready_q <= 1'b0;
      hi_byte    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= next_state;
      rx_ready_q <= (next_state == HI) || (next_state == LO);
      if (state == HI && xfer && !abort)
        hi_byte <= bus.rx_data;
      if (state == LO && xfer && !abort)
        data_q <= {hi_byte, bus.rx_data};
      if ((state == IDLE && next_state == HI) || (in_frame && abort))
        addr_q <= '0;
      else if (state == WR && next_state == HI)
        addr_q <= addr_q + 1'b1;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = (state == WR) && !abort;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = data_q;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);

`ifdef PIC_RAM_WRITER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge vga_clk) begin
    if (!rst_n)
      sum_q <= '0;
    else if (state == IDLE && next_state == HI)
      sum_q <= '0;
    else if (bus.wr_en)
      sum_q <= sum_q + data_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_pic_ram_writer.sv
// Self-checking bench for pic_ram_writer: randomized byte streams compared every
// cycle against a frame-level model, plus literal checks on key scenarios.
module tb_pic_ram_writer;

  localparam int PIX = 48 * 48;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        frame_done;
  logic [15:0] checksum;

  pic_ram_writer_if bus();

  pic_ram_writer #(.WIDTH(48), .HEIGHT(48)) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .frame_done (frame_done),
    .checksum   (checksum),
    .bus        (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int tests = 0;
  int fails = 0;

  // Model of the frame: what the writer owes the outside world after each edge
  bit          mValid = 1'b0;
  bit          mActive, mWr, mDone;
  int          mBytes, mIdx;
  logic [7:0]  mHi;
  logic [15:0] mPix, mSum;

  int          wrCount, doneCount, firstAddr;
  logic [15:0] firstData;
  bit          seenFirst;
  logic        eWr;
  logic [15:0] eSum;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (mValid) begin
      eWr = mWr && !abort;
`ifdef PIC_RAM_WRITER_CHECKSUM_EN
      eSum = mSum;
`else
      eSum = 16'h0000;
`endif
      checkOutput("busy", busy, mActive);
      checkOutput("rx_ready", bus.rx_ready, mActive && !mWr && !mDone);
      checkOutput("wr_en", bus.wr_en, eWr);
      checkOutput("frame_done", frame_done, mDone);
      checkOutput("wr_addr", bus.wr_addr, 32'(mIdx));
      checkOutput("checksum", checksum, eSum);
      if (eWr) checkOutput("wr_data", bus.wr_data, mPix);
    end
    if (bus.wr_en === 1'b1) begin
      wrCount++;
      if (!seenFirst) begin
        seenFirst = 1'b1;
        firstData = bus.wr_data;
        firstAddr = int'(bus.wr_addr);
      end
    end
    if (frame_done === 1'b1) doneCount++;

    // advance the model across the coming edge
    if (!rst_n) begin
      mValid = 1'b1; mActive = 1'b0; mWr = 1'b0; mDone = 1'b0;
      mBytes = 0; mIdx = 0; mHi = 8'h00; mPix = 16'h0000; mSum = 16'h0000;
    end else if (mValid) begin
      if (!mActive) begin
        if (start && !abort) begin
          mActive = 1'b1; mBytes = 0; mIdx = 0; mSum = 16'h0000;
        end
      end else if (mDone) begin
        mDone = 1'b0; mActive = 1'b0;
      end else if (abort) begin
        mActive = 1'b0; mWr = 1'b0; mBytes = 0; mIdx = 0;
      end else if (mWr) begin
        mWr = 1'b0;
        mSum = mSum + mPix;
        if (mIdx == PIX - 1) mDone = 1'b1;
        else mIdx++;
      end else if (bus.rx_valid) begin
        if (mBytes == 0) begin
          mHi = bus.rx_data; mBytes = 1;
        end else begin
          mPix = {mHi, bus.rx_data}; mWr = 1'b1; mBytes = 0;
        end
      end
    end
  end

  function automatic logic [7:0] byteFor(input int pattern, input int k);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (pattern == 1 && k == 0) b = 8'hF8;
    if (pattern == 1 && k == 1) b = 8'h00;
    if (pattern == 2) b = (k % 2 == 0) ? 8'h00 : 8'h01;
    return b;
  endfunction

  task automatic applyStimulus(input int nBytes, input int pattern, input bit randValid);
    int sent = 0;
    int guard = 0;
    logic [7:0] b;
    b = byteFor(pattern, 0);
    while (sent < nBytes && guard < 40000) begin
      @(posedge vga_clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = randValid ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge vga_clk);
      if (bus.rx_valid && bus.rx_ready === 1'b1) begin
        sent++;
        b = byteFor(pattern, sent);
      end
      guard++;
    end
    if (sent < nBytes) checkOutput("stim_timeout", sent, nBytes);
    @(posedge vga_clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic startPulse();
    @(posedge vga_clk); #1 start = 1'b1;
    @(posedge vga_clk); #1 start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (frame_done !== 1'b1 && n < 50) begin
      @(negedge vga_clk);
      n++;
    end
    checkOutput("frame_done_seen", frame_done, 1'b1);
    @(negedge vga_clk);
    checkOutput("busy_after_done", busy, 1'b0);
  endtask

  task automatic clearStats();
    wrCount = 0; doneCount = 0; seenFirst = 1'b0; firstAddr = -1; firstData = 16'hxxxx;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
    checkOutput({tag, "_wr_en"}, bus.wr_en, 1'b0);
    checkOutput({tag, "_wr_addr"}, bus.wr_addr, 32'h0);
    checkOutput({tag, "_wr_data"}, bus.wr_data, 32'h0);
    checkOutput({tag, "_frame_done"}, frame_done, 1'b0);
    checkOutput({tag, "_checksum"}, checksum, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    clearStats();
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    checkResetValues("reset");
    @(posedge vga_clk); #1 rst_n = 1'b1;

    // full frame, rx_valid held high, first pixel 0xF800
    clearStats();
    startPulse();
    applyStimulus(2 * PIX, 1, 1'b0);
    waitDone();
    checkOutput("f1_wr_count", wrCount, PIX);
    checkOutput("f1_done_count", doneCount, 1);
    checkOutput("f1_first_data", firstData, 16'hF800);
    checkOutput("f1_first_addr", firstAddr, 0);

    // random rx_valid, start held high while busy
    clearStats();
    fork
      begin
        @(posedge vga_clk); #1 start = 1'b1;
        repeat (40) @(posedge vga_clk);
        #1 start = 1'b0;
      end
      begin
        repeat (2) @(posedge vga_clk);
        applyStimulus(2 * PIX, 0, 1'b1);
      end
    join
    waitDone();
    checkOutput("f2_wr_count", wrCount, PIX);
    checkOutput("f2_done_count", doneCount, 1);

    // abort after 3 pixels and one extra byte
    clearStats();
    startPulse();
    applyStimulus(7, 0, 1'b0);
    doneBefore = doneCount;
    abort = 1'b1;
    @(posedge vga_clk); #1 abort = 1'b0;
    @(negedge vga_clk);
    checkOutput("abort_wr_addr", bus.wr_addr, 32'h0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_wr_count", wrCount, 3);
    repeat (3) @(negedge vga_clk);
    checkOutput("abort_no_done", doneCount, doneBefore);

    // full frame of 0x0001 pixels after the abort, random rx_valid
    clearStats();
    startPulse();
    applyStimulus(2 * PIX, 2, 1'b1);
    waitDone();
    checkOutput("f4_first_addr", firstAddr, 0);
    checkOutput("f4_wr_count", wrCount, PIX);
`ifdef PIC_RAM_WRITER_CHECKSUM_EN
    checkOutput("f4_checksum", checksum, 16'h0900);
`else
    checkOutput("f4_checksum", checksum, 16'h0000);
`endif

    // reset while in LO at pixel 100
    clearStats();
    startPulse();
    applyStimulus(201, 0, 1'b0);
    rst_n = 1'b0;
    bus.rx_valid = 1'b1;
    @(posedge vga_clk);
    @(negedge vga_clk);
    checkResetValues("midreset");
    repeat (5) @(negedge vga_clk);
    bus.rx_valid = 1'b0;
    @(posedge vga_clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge vga_clk);
    checkOutput("midreset_wr_count", wrCount, 100);
    checkOutput("midreset_no_done", doneCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
